// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send and
// shifts one command byte out on device-generated clock edges, then checks the ack.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 7094,
  parameter int TIMEOUT_CYCLES = 1064070,
  parameter int CNT_W          = 21
) (
  input  logic       clk_i,
  input  logic       res_n_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic       tx_done_o,
  output logic       tx_error_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_dat_oe_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  localparam logic [CNT_W-1:0] INHIBIT_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
  localparam logic [3:0]       LAST_DATA_EDGE = 4'd9;
  localparam logic [3:0]       STOP_EDGE_CNT  = 4'd10;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [8:0]       shift_q, shift_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;

  logic [1:0]       clk_sync_q, dat_sync_q;
  logic             sync_clk_prev_q;
  logic             sync_clk, sync_dat, fall_edge, timeout_hit;

  // Both bus lines idle high, so the synchronisers reset to 1 to avoid a phantom edge.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      clk_sync_q      <= 2'b11;
      dat_sync_q      <= 2'b11;
      sync_clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q      <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q      <= {dat_sync_q[0], ps2_dat_i};
      sync_clk_prev_q <= clk_sync_q[1];
    end
  end

  assign sync_clk    = clk_sync_q[1];
  assign sync_dat    = dat_sync_q[1];
  assign fall_edge   = sync_clk_prev_q & ~sync_clk;
  assign timeout_hit = (cnt_q == TIMEOUT_LAST);
  assign cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_ONE;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    clk_oe_d   = clk_oe_q;
    dat_oe_d   = dat_oe_q;
    tx_done_o  = 1'b0;
    tx_error_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_valid_i) begin
          shift_d  = {~^tx_data_i, tx_data_i};
          cnt_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q >= INHIBIT_LAST) begin
          dat_oe_d = 1'b1;
          state_d  = S_REQ;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_REQ: begin
        clk_oe_d  = 1'b0;
        bit_cnt_d = '0;
        cnt_d     = '0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d = cnt_inc;
        if (fall_edge) begin
          if (bit_cnt_q < LAST_DATA_EDGE) begin
            dat_oe_d  = ~shift_q[0];
            shift_d   = {1'b0, shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            dat_oe_d  = 1'b0;
            bit_cnt_d = STOP_EDGE_CNT;
            state_d   = S_ACK;
          end
        end
      end
      S_ACK: begin
        cnt_d = cnt_inc;
        if (fall_edge) begin
          if (!sync_dat) begin
            state_d = S_WAIT_IDLE;
          end else begin
            tx_error_o = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        cnt_d = cnt_inc;
        if (sync_clk && sync_dat) begin
          tx_done_o = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Timeout overrides anything the device clocked in during the same cycle.
    if (timeout_hit && (state_q inside {S_SHIFT, S_ACK, S_WAIT_IDLE})) begin
      clk_oe_d   = 1'b0;
      dat_oe_d   = 1'b0;
      tx_done_o  = 1'b0;
      tx_error_o = 1'b1;
      state_d    = S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
    end
  end

  assign tx_ready_o   = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign ps2_clk_oe_o = clk_oe_q;
  assign ps2_dat_oe_o = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks frames out of the
// host and every sampled frame is compared with a byte-level reference model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 500;

  logic       clk = 1'b0;
  logic       res_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low, dev_dat_low;
  logic       ps2_clk_line, ps2_dat_line;

  int         vectors = 0;
  int         miscompares = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  logic       pulse_prev = 1'b0;
  logic       ready_at_pulse = 1'b1;
  logic       ready_after = 1'b0;
  logic [1:0] oe_after = 2'b11;

  always #5 clk = ~clk;

  // Open-drain bus: either side pulling low wins.
  assign ps2_clk_line = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_line = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (21)
  ) dut (
    .clk_i       (clk),
    .res_n_i     (res_n),
    .tx_data_i   (tx_data),
    .tx_valid_i  (tx_valid),
    .tx_ready_o  (tx_ready),
    .busy_o      (busy),
    .tx_done_o   (tx_done),
    .tx_error_o  (tx_error),
    .ps2_clk_i   (ps2_clk_line),
    .ps2_dat_i   (ps2_dat_line),
    .ps2_clk_oe_o(ps2_clk_oe),
    .ps2_dat_oe_o(ps2_dat_oe)
  );

  always @(negedge clk) begin
    pulse_prev <= tx_done | tx_error;
    if (tx_done)  done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt  <= err_cnt + 1;
    if (tx_done | tx_error) ready_at_pulse <= tx_ready;
    if (pulse_prev) begin
      ready_after <= tx_ready;
      oe_after    <= {ps2_clk_oe, ps2_dat_oe};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line levels seen at device sample points 1..10: data LSB first, odd parity, stop.
  function automatic logic [9:0] frame_model(input logic [7:0] d);
    logic [9:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = d[i];
      if (d[i]) ones++;
    end
    f[8] = ((ones % 2) == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_request(output int hi_len, output int req_len, output bit ok);
    int guard;
    hi_len  = 0;
    req_len = 0;
    ok      = 1'b0;
    guard   = 0;
    while (ps2_clk_oe !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (ps2_clk_oe !== 1'b1) return;
    guard = 0;
    while (ps2_clk_oe === 1'b1 && guard < 200) begin
      hi_len++;
      if (ps2_dat_oe === 1'b1) req_len++;
      @(negedge clk);
      guard++;
    end
    ok = (ps2_clk_oe === 1'b0);
  endtask

  task automatic device_clock(input int half, input bit ack, input int stop_at,
                              output logic [9:0] bits);
    bits = '0;
    for (int e = 1; e <= 11; e++) begin
      if (e == 11 && ack) begin
        repeat (half / 2) @(negedge clk);
        dev_dat_low = 1'b1;
        repeat (half - half / 2) @(negedge clk);
      end else begin
        repeat (half) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      if (e == stop_at) return;
      repeat (half) @(negedge clk);
      if (e <= 10) bits[e-1] = ps2_dat_line;
      dev_clk_low = 1'b0;
    end
    repeat (2) @(negedge clk);
    dev_dat_low = 1'b0;
  endtask

  task automatic expect_outcome(input string tag, input bit want_done,
                                input int base_done, input int base_err);
    int guard;
    guard = 0;
    while ((done_cnt + err_cnt) == (base_done + base_err) && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt - base_done, want_done ? 1 : 0);
    check({tag, "_err_pulses"}, err_cnt - base_err, want_done ? 0 : 1);
    check({tag, "_ready_at_pulse"}, ready_at_pulse, 0);
    check({tag, "_ready_after"}, ready_after, 1);
    check({tag, "_oe_after"}, oe_after, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_frame(input logic [7:0] d, input int half, input bit ack,
                           input bit poke_busy, input string tag);
    int hi, rq, bd, be;
    bit ok;
    logic [9:0] bits;
    bd = done_cnt;
    be = err_cnt;
    send_byte(d);
    if (poke_busy) begin
      @(negedge clk);
      check({tag, "_ready_while_busy"}, tx_ready, 0);
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
    end
    wait_request(hi, rq, ok);
    check({tag, "_request"}, ok, 1);
    if (ok) begin
      if (!poke_busy) check({tag, "_inhibit_len"}, hi, INH + 1);
      check({tag, "_req_cycles"}, rq, 1);
      check({tag, "_start_bit"}, ps2_dat_line, 0);
      device_clock(half, ack, 0, bits);
      check({tag, "_frame"}, bits, frame_model(d));
    end
    expect_outcome(tag, ack, bd, be);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, hi, rq, bd, be;
    bit ok;
    logic [9:0] bits;
    logic [7:0] d;

    res_n       = 1'b0;
    tx_data     = 8'h00;
    tx_valid    = 1'b0;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    check("rst_pulses", {tx_done, tx_error}, 0);
    res_n = 1'b1;
    repeat (3) @(negedge clk);

    run_frame(8'hED, 8, 1'b1, 1'b0, "ed");
    run_frame(8'h00, 7, 1'b1, 1'b0, "x00");
    run_frame(8'h01, 10, 1'b1, 1'b0, "x01");

    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      run_frame(d, int'($urandom_range(6, 12)), 1'b1, 1'b0, $sformatf("rand%0d_%02h", i, d));
    end

    run_frame(8'h5A, 8, 1'b0, 1'b0, "nack");

    // Device never clocks: abort exactly TMO cycles after clock release.
    bd = done_cnt;
    be = err_cnt;
    send_byte(8'hA5);
    wait_request(hi, rq, ok);
    check("tmo_request", ok, 1);
    n = 1;
    while (!tx_error && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", n, TMO);
    check("tmo_ready_at_pulse", tx_ready, 0);
    @(negedge clk);
    check("tmo_ready_next", tx_ready, 1);
    check("tmo_oe_next", {ps2_clk_oe, ps2_dat_oe}, 0);
    repeat (3) @(negedge clk);
    check("tmo_no_done", done_cnt - bd, 0);
    check("tmo_one_err", err_cnt - be, 1);

    // Reset while the device holds the clock low for edge 5.
    bd = done_cnt;
    be = err_cnt;
    send_byte(8'h00);
    wait_request(hi, rq, ok);
    check("rstmid_request", ok, 1);
    device_clock(8, 1'b1, 5, bits);
    repeat (5) @(negedge clk);
    check("rstmid_dat_before", ps2_dat_oe, 1);
    #2 res_n = 1'b0;
    #1;
    check("rstmid_oe_async", {ps2_clk_oe, ps2_dat_oe}, 0);
    check("rstmid_ready", tx_ready, 1);
    check("rstmid_busy", busy, 0);
    dev_clk_low = 1'b0;
    @(negedge clk);
    res_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmid_no_pulse", (done_cnt + err_cnt) - (bd + be), 0);
    run_frame(8'hFF, 9, 1'b1, 1'b0, "xff_after_rst");

    // A request while busy is dropped: one frame, no follow-up transfer.
    run_frame(8'h3C, 8, 1'b1, 1'b1, "busy_drop");
    repeat (5) @(negedge clk);
    check("busy_drop_no_second", {busy, ps2_clk_oe}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
